// File: rtl/cnn_pkg.sv
// cnn_pkg: window FSM encoding and window-legality helper
// shared by the CNN front-end blocks.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } win_state_e;

    // A pixel at (row, col) closes a window when it sits on the stride grid
    // anchored at (k-1, k-1).
    function automatic logic win_legal(
        input int row,
        input int col,
        input int k,
        input int stride
    );
        int dr;
        int dc;
        dr = row - (k - 1);
        dc = col - (k - 1);
        if (dr < 0 || dc < 0) return 1'b0;
        return ((dr % stride) == 0) && ((dc % stride) == 0);
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// pixel_pos_counter: column/row position of the pixel presented this cycle.
// frame_start (with data_valid) forces the pixel to (0,0).
module pixel_pos_counter #(
    parameter int ROW_SIZE = 5,
    parameter int COL_SIZE = 5,
    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1,
    localparam int RW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          data_valid,
    input  logic          frame_start,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    localparam logic [CW-1:0] COL_MAX = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(COL_SIZE - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          restart;

    // Current position and next counter values; only accepted pixels advance.
    always_comb begin
        restart = data_valid & frame_start;
        col     = restart ? '0 : col_q;
        row     = restart ? '0 : row_q;
        last    = (col == COL_MAX) && (row == ROW_MAX);
        col_d   = col_q;
        row_d   = row_q;
        if (data_valid) begin
            if (col == COL_MAX) begin
                col_d = '0;
                row_d = (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col_d = col + CW'(1);
                row_d = row;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sliding_window_ctrl.sv
// sliding_window_ctrl: K x K window capture from external line-buffer taps.
// Define SLIDING_WINDOW_POS_OUT_EN to add win_row/win_col position outputs.
module sliding_window_ctrl
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ROW_SIZE    = 5,
    parameter int COL_SIZE    = 5,
    parameter int STRIDE      = 1,
    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1,
    localparam int RW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1,
    localparam int WW = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          data_valid,
    input  logic          frame_start,
    input  logic [WW-1:0] taps,
    output logic [WW-1:0] window_out,
    output logic          window_valid,
    output logic          frame_done
`ifdef SLIDING_WINDOW_POS_OUT_EN
    ,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col
`endif
);

    localparam int K  = KERNEL_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam logic [RW-1:0] KROW = RW'(K - 1);
    localparam logic [CW-1:0] KCOL = CW'(K - 1);

    logic [CW-1:0] pix_col;
    logic [RW-1:0] pix_row;
    logic          pix_last;

    pixel_pos_counter #(
        .ROW_SIZE (ROW_SIZE),
        .COL_SIZE (COL_SIZE)
    ) u_pos (
        .clock       (clock),
        .reset       (reset),
        .data_valid  (data_valid),
        .frame_start (frame_start),
        .col         (pix_col),
        .row         (pix_row),
        .last        (pix_last)
    );

    win_state_e    state_q, state_d;
    logic          leg_q, leg_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic [WW-1:0] win_q, win_d;

    // Frame FSM; DONE lines up with the final window because the last
    // pixel is seen through the same one-cycle stage as the window load.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_DONE) state_d = ST_FILL;
        if (data_valid) begin
            if (pix_row == KROW && pix_col == '0) state_d = ST_RUN;
            else if (frame_start) state_d = ST_FILL;
        end
        if (last_q) state_d = ST_DONE;
    end

    // Taps reflect the line buffers after an accepted pixel, so the
    // legality decision is staged and the window loads one edge later.
    always_comb begin
        leg_d   = data_valid &&
                  win_legal(int'(pix_row), int'(pix_col), K, STRIDE);
        last_d  = data_valid && pix_last;
        valid_d = leg_q;
        win_d   = win_q;
        if (leg_q) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_d[(r*K+c)*DW +: DW] =
                        taps[((K-1-r)*K + (K-1-c))*DW +: DW];
                end
            end
        end
    end

    // FSM, stage and window registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            leg_q   <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            leg_q   <= leg_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            win_q   <= win_d;
        end
    end

    assign window_out   = win_q;
    assign window_valid = valid_q;
    assign frame_done   = (state_q == ST_DONE);

`ifdef SLIDING_WINDOW_POS_OUT_EN
    logic [RW-1:0] prow_q, prow_d, wrow_q, wrow_d;
    logic [CW-1:0] pcol_q, pcol_d, wcol_q, wcol_d;

    // Top-left coordinate staged alongside the legality flag.
    always_comb begin
        prow_d = pix_row - KROW;
        pcol_d = pix_col - KCOL;
        wrow_d = leg_q ? prow_q : wrow_q;
        wcol_d = leg_q ? pcol_q : wcol_q;
    end

    // Position registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prow_q <= '0;
            pcol_q <= '0;
            wrow_q <= '0;
            wcol_q <= '0;
        end else begin
            prow_q <= prow_d;
            pcol_q <= pcol_d;
            wrow_q <= wrow_d;
            wcol_q <= wcol_d;
        end
    end

    assign win_row = wrow_q;
    assign win_col = wcol_q;
`endif

endmodule

// File: doc/sliding_window_ctrl.md
SLIDING_WINDOW_CTRL -- requirements
Module: sliding_window_ctrl

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, window edge length K.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-003 SHALL have parameter ROW_SIZE, default 5, pixels per image row.
REQ-004 SHALL have parameter COL_SIZE, default 5, rows per frame.
REQ-005 SHALL have parameter STRIDE, default 1, legal values 1 or 2, window step in both axes.
REQ-006 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port data_valid, input, 1, pixel accepted by the line buffers this edge.
REQ-009 SHALL have port frame_start, input, 1, qualified by data_valid; marks pixel (0,0).
REQ-010 SHALL have port taps, input, K*K*DATA_WIDTH, K line-buffer tap groups; group g (bits [(g+1)*K*DW-1 : g*K*DW]) from buffer g, g=0 newest row; element e within a group, e=0 newest pixel.
REQ-011 SHALL have port window_out, output, K*K*DATA_WIDTH, registered window; slot (r*K+c) holds row r (0 = top/oldest), col c (0 = left/oldest).
REQ-012 SHALL have port window_valid, output, 1, one-cycle pulse per legal window.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse after last pixel of frame.

Function
REQ-014 SHALL track col_cnt (0..ROW_SIZE-1) and row_cnt (0..COL_SIZE-1) of the incoming pixel, widths $clog2 of each size; increment only on data_valid.
REQ-015 col_cnt SHALL wrap to 0 after ROW_SIZE-1 and increment row_cnt; row_cnt SHALL wrap to 0 after COL_SIZE-1.
REQ-016 data_valid with frame_start SHALL treat the pixel as (0,0) regardless of counters; counters then become (1,0) (or (0,1) when ROW_SIZE=1).
REQ-017 FSM states: FILL (row_cnt < K-1), RUN, DONE; FILL->RUN when a pixel at row K-1 col 0 is accepted; RUN->DONE when pixel (COL_SIZE-1, ROW_SIZE-1) is accepted; DONE->FILL unconditionally next cycle; frame_start in any state forces FILL/RUN per its new position.
REQ-018 Pixel accepted at edge N is legal when row>=K-1, col>=K-1, (row-(K-1))%STRIDE==0, (col-(K-1))%STRIDE==0.
REQ-019 For a legal pixel accepted at edge N, at edge N+1 window_out SHALL load slot (r*K+c) from taps group K-1-r element K-1-c, and window_valid SHALL be 1 for that cycle only.
REQ-020 window_out SHALL hold its value when window_valid is 0.
REQ-021 frame_done SHALL assert for exactly the cycle in DONE; it SHALL coincide with the final window_valid.
REQ-022 Gaps in data_valid SHALL NOT change counters, state or outputs.

Reset
REQ-023 reset SHALL asynchronously force col_cnt=0, row_cnt=0, state FILL, window_out=0, window_valid=0, frame_done=0.
REQ-024 Reset mid-frame SHALL discard the partial frame; first pixel after release is (0,0).

Configuration
REQ-025 Macro SLIDING_WINDOW_POS_OUT_EN defined: add outputs win_row ($clog2(COL_SIZE)) and win_col ($clog2(ROW_SIZE)), registered with window_out, holding the top-left coordinate (row-(K-1), col-(K-1)) of the window; reset 0.
REQ-026 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-027 FSM state encoding (FILL, RUN, DONE) and STRIDE legality check SHALL live in shared package cnn_pkg.
REQ-028 Counter pair SHALL be sub-module pixel_pos_counter (ports clock, reset, data_valid, frame_start, col, row, last).
REQ-029 K line buffers SHALL be external; this block contains no pixel storage beyond window_out.

Verification (K=3, 5x5, pixel value = index 0..24)
REQ-030 Stream 25 pixels continuous, STRIDE=1 -> 9 window_valid pulses, first one cycle after pixel 12, window_out slots 0..8 = 0,1,2,5,6,7,10,11,12; frame_done with 9th.
REQ-031 STRIDE=2 same stream -> 4 pulses, after pixels 12,14,22,24.
REQ-032 data_valid toggled every other cycle -> same 9 windows and values, pulses 2 cycles apart min.
REQ-033 reset pulsed after pixel 15 then fresh frame -> no pulse before new pixel 12; first window 0,1,2,5,6,7,10,11,12.
REQ-034 frame_start reasserted at pixel 8 -> counters restart; first window after 12th pixel counted from restart.
REQ-035 With SLIDING_WINDOW_POS_OUT_EN, STRIDE=1 -> first window win_row=0, win_col=0; last win_row=2, win_col=2.
